// File: rtl/serpent_sbox_iter.sv
// Iterative Serpent S-box layer: SLICES bit-slices per cycle, valid/ready on both sides.
// Define SERPENT_SBOX_INVERSE_EN to build the inverse tables and honour dec.
module serpent_sbox_iter #(
    parameter int unsigned SLICES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  sel,
    input  logic        dec,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y0,
    output logic [31:0] y1,
    output logic [31:0] y2,
    output logic [31:0] y3,
    output logic        busy
);

    localparam int unsigned N  = 32 / SLICES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (!(SLICES == 1 || SLICES == 2 || SLICES == 4 ||
          SLICES == 8 || SLICES == 16 || SLICES == 32)) begin : g_bad_slices
        $error("serpent_sbox_iter: SLICES must be 1, 2, 4, 8, 16 or 32");
    end

    // Nibble k of each entry is S(k).
    localparam logic [63:0] SBOX [8] = '{
        64'hC90724DE_B56A1F83,
        64'h43D68EB1_A50972CF,
        64'h25B04E1D_FAC39768,
        64'hE57A421D_369C8BF0,
        64'hD7E9A452_6B0C38F1,
        64'h176D8E30_C9A4B25F,
        64'h0A3DF19E_B6485C27,
        64'h6539AC47_B28E0FD1
    };

    function automatic logic [3:0] f_fwd(input logic [2:0] s, input logic [3:0] v);
        logic [63:0] t;
        t = SBOX[s];
        return t[{v, 2'b00} +: 4];
    endfunction

`ifdef SERPENT_SBOX_INVERSE_EN
    function automatic logic [3:0] f_inv(input logic [2:0] s, input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (f_fwd(s, 4'(k)) == v) r = 4'(k);
        end
        return r;
    endfunction
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_x0, r_x1, r_x2, r_x3;
    logic [2:0]      r_sel;
    logic [31:0]     r_y0, r_y1, r_y2, r_y3;
    logic [31:0]     w_y0_nxt, w_y1_nxt, w_y2_nxt, w_y3_nxt;
    logic            w_accept;

`ifdef SERPENT_SBOX_INVERSE_EN
    logic            r_dec;
`else
    logic            w_unused_dec;
    assign w_unused_dec = dec;
`endif

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign y0 = r_y0;
    assign y1 = r_y1;
    assign y2 = r_y2;
    assign y3 = r_y3;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == CW'(N - 1)) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = in_valid ? S_BUSY : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        logic [4:0] w_idx;
        logic [3:0] w_nib;
        logic [3:0] w_sub;
        w_y0_nxt = r_y0;
        w_y1_nxt = r_y1;
        w_y2_nxt = r_y2;
        w_y3_nxt = r_y3;
        w_idx    = '0;
        w_nib    = '0;
        w_sub    = '0;
        for (int unsigned j = 0; j < SLICES; j++) begin
            w_idx = 5'(32'(r_cnt) * SLICES + j);
            w_nib = {r_x3[w_idx], r_x2[w_idx], r_x1[w_idx], r_x0[w_idx]};
`ifdef SERPENT_SBOX_INVERSE_EN
            w_sub = r_dec ? f_inv(r_sel, w_nib) : f_fwd(r_sel, w_nib);
`else
            w_sub = f_fwd(r_sel, w_nib);
`endif
            w_y0_nxt[w_idx] = w_sub[0];
            w_y1_nxt[w_idx] = w_sub[1];
            w_y2_nxt[w_idx] = w_sub[2];
            w_y3_nxt[w_idx] = w_sub[3];
        end
    end

    // Acceptance out of DONE takes priority over the BUSY update, as they share an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_y3    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_x0  <= x0;
                r_x1  <= x1;
                r_x2  <= x2;
                r_x3  <= x3;
                r_sel <= sel;
`ifdef SERPENT_SBOX_INVERSE_EN
                r_dec <= dec;
`endif
                r_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_y0  <= w_y0_nxt;
                r_y1  <= w_y1_nxt;
                r_y2  <= w_y2_nxt;
                r_y3  <= w_y3_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serpent_sbox_iter.sv
// Directed and randomised checks of serpent_sbox_iter at SLICES = 4, 1 and 32.
module tb_serpent_sbox_iter;

    typedef struct {
        logic [2:0]  sel;
        logic        dec;
        logic [31:0] x0, x1, x2, x3;
        logic [31:0] y0, y1, y2, y3;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned SB [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, a_in_ready, a_dec, a_out_valid, a_out_ready, a_busy;
    logic [2:0]  a_sel;
    logic [31:0] a_x0, a_x1, a_x2, a_x3, a_y0, a_y1, a_y2, a_y3;

    logic        b_in_valid, b_dec, b_out_ready;
    logic [2:0]  b_sel;
    logic [31:0] b_x0, b_x1, b_x2, b_x3;
    logic        p_in_ready, p_out_valid, p_busy, q_in_ready, q_out_valid, q_busy;
    logic [31:0] p_y0, p_y1, p_y2, p_y3, q_y0, q_y1, q_y2, q_y3;

    serpent_sbox_iter #(.SLICES(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .dec(a_dec), .x0(a_x0), .x1(a_x1), .x2(a_x2), .x3(a_x3),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3), .busy(a_busy)
    );

    serpent_sbox_iter #(.SLICES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(p_in_ready),
        .sel(b_sel), .dec(b_dec), .x0(b_x0), .x1(b_x1), .x2(b_x2), .x3(b_x3),
        .out_valid(p_out_valid), .out_ready(b_out_ready),
        .y0(p_y0), .y1(p_y1), .y2(p_y2), .y3(p_y3), .busy(p_busy)
    );

    serpent_sbox_iter #(.SLICES(32)) u_s32 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(q_in_ready),
        .sel(b_sel), .dec(b_dec), .x0(b_x0), .x1(b_x1), .x2(b_x2), .x3(b_x3),
        .out_valid(q_out_valid), .out_ready(b_out_ready),
        .y0(q_y0), .y1(q_y1), .y2(q_y2), .y3(q_y3), .busy(q_busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: per-slice table lookup, inverse by searching the forward table.
    function automatic logic [127:0] model(input logic [2:0] s, input logic d,
                                           input logic [31:0] p0, p1, p2, p3);
        logic [31:0] r0, r1, r2, r3;
        int unsigned nib, o;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0;
        for (int i = 0; i < 32; i++) begin
            nib = {28'd0, p3[i], p2[i], p1[i], p0[i]};
            o = SB[s][nib];
            if (d) begin
                for (int unsigned k = 0; k < 16; k++)
                    if (SB[s][k] == nib) o = k;
            end
            r0[i] = o[0]; r1[i] = o[1]; r2[i] = o[2]; r3[i] = o[3];
        end
        return {r3, r2, r1, r0};
    endfunction

    task automatic blk4(input logic [2:0] s, input logic d, input logic [31:0] p0, p1, p2, p3,
                        output int lat, output logic [127:0] y);
        a_sel = s; a_dec = d; a_x0 = p0; a_x1 = p1; a_x2 = p2; a_x3 = p3;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 40) begin @(negedge clk); lat++; end
        y = {a_y3, a_y2, a_y1, a_y0};
        @(negedge clk);
    endtask

    vec_t tv [10];
    logic inv_en;

    initial begin
        int          lat, lat1, lat32;
        logic [127:0] y, y1r, y32r, exp;
        logic [31:0] r0, r1, r2, r3;
        logic        seen, d, de;
        logic [2:0]  s;

`ifdef SERPENT_SBOX_INVERSE_EN
        inv_en = 1'b1;
`else
        inv_en = 1'b0;
`endif
        tv[0] = '{3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
        tv[1] = '{3'd7, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        tv[2] = '{3'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tv[3] = '{3'd3, 1'b0, 32'h0000FFFF, 32'h0, 32'h0, 32'h0,
                  32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
        tv[4] = '{3'd4, 1'b0, 32'hAAAAAAAA, 32'h0, 32'h0, 32'h0,
                  32'hFFFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA};
        tv[5] = '{3'd6, 1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF,
                  32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tv[6] = '{3'd2, 1'b0, 32'h0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0,
                  32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0, 32'h0F0F0F0F};
        tv[7] = '{3'd5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
        if (inv_en) begin
            tv[8] = '{3'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                      32'h0, 32'h0, 32'h0, 32'h0};
            tv[9] = '{3'd7, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
                      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
        end else begin
            tv[8] = '{3'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                      32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
            tv[9] = '{3'd7, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
                      32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
        end

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_sel = '0; a_dec = 1'b0;
        a_x0 = '0; a_x1 = '0; a_x2 = '0; a_x3 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_sel = '0; b_dec = 1'b0;
        b_x0 = '0; b_x1 = '0; b_x2 = '0; b_x3 = '0;
        repeat (2) @(negedge clk);

        chk("rst_s4", {a_out_valid, a_busy, a_in_ready, a_y3, a_y2, a_y1, a_y0},
            {1'b0, 1'b0, 1'b1, 128'h0});
        chk("rst_s1", {p_out_valid, p_busy, p_in_ready, p_y3, p_y2, p_y1, p_y0},
            {1'b0, 1'b0, 1'b1, 128'h0});
        chk("rst_s32", {q_out_valid, q_busy, q_in_ready, q_y3, q_y2, q_y1, q_y0},
            {1'b0, 1'b0, 1'b1, 128'h0});
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            blk4(tv[v].sel, tv[v].dec, tv[v].x0, tv[v].x1, tv[v].x2, tv[v].x3, lat, y);
            chk($sformatf("vec%0d_lat", v), 128'(lat), 128'(8));
            chk($sformatf("vec%0d_y", v), y, {tv[v].y3, tv[v].y2, tv[v].y1, tv[v].y0});
        end

        // Stall in DONE, then consume and accept on the same edge.
        a_sel = 3'd0; a_dec = 1'b0; a_x0 = '0; a_x1 = '0; a_x2 = '0; a_x3 = '0;
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("stall_lat", 128'(lat), 128'(8));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d", c), {a_out_valid, a_in_ready, a_y3, a_y2, a_y1, a_y0},
                {1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF});
        end
        a_sel = 3'd7; a_x0 = '1; a_x1 = '1; a_x2 = '1; a_x3 = '1;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1 chk("done_in_ready", 128'(a_in_ready), 128'(1));
        @(posedge clk); @(negedge clk);
        chk("b2b_busy", {126'h0, a_out_valid, a_busy}, {126'h0, 1'b0, 1'b1});
        lat = 0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("busy_holdoff%0d", c), 128'(a_in_ready), 128'(0));
            a_sel = 3'd3; a_x0 = 32'h12345678;
            @(negedge clk); lat++;
        end
        a_in_valid = 1'b0;
        while (!a_out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("b2b_lat", 128'(lat), 128'(8));
        chk("b2b_y", {a_y3, a_y2, a_y1, a_y0}, {32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0});
        @(negedge clk);

        // Reset at cnt==3 aborts the block.
        a_sel = 3'd0; a_x0 = '0; a_x1 = '0; a_x2 = '0; a_x3 = '0;
        a_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", 128'(a_busy), 128'(1));
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort", {a_out_valid, a_busy, a_in_ready, a_y3, a_y2, a_y1, a_y0},
            {1'b0, 1'b0, 1'b1, 128'h0});
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (a_out_valid) seen = 1'b1; end
        chk("abort_no_result", 128'(seen), 128'(0));

        if (inv_en) begin
            for (int k = 0; k < 8; k++) begin
                s = 3'(k);
                r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
                blk4(s, 1'b0, r0, r1, r2, r3, lat, y);
                chk($sformatf("rt_fwd%0d", k), y, model(s, 1'b0, r0, r1, r2, r3));
                blk4(s, 1'b1, y[31:0], y[63:32], y[95:64], y[127:96], lat, y);
                chk($sformatf("rt_inv%0d", k), y, {r3, r2, r1, r0});
            end
        end

        // SLICES=1 and SLICES=32 share stimulus; out_ready stays high.
        for (int b = 0; b < 100; b++) begin
            s = 3'($urandom_range(7));
            d = 1'($urandom_range(1));
            de = d & inv_en;
            b_sel = s; b_dec = d;
            b_x0 = $urandom; b_x1 = $urandom; b_x2 = $urandom; b_x3 = $urandom;
            exp = model(s, de, b_x0, b_x1, b_x2, b_x3);
            b_in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            b_in_valid = 1'b0;
            b_x0 = ~b_x0; b_x1 = '0;
            lat1 = 0; lat32 = 0; y1r = '0; y32r = '0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (p_out_valid && lat1 == 0) begin lat1 = k; y1r = {p_y3, p_y2, p_y1, p_y0}; end
                if (q_out_valid && lat32 == 0) begin lat32 = k; y32r = {q_y3, q_y2, q_y1, q_y0}; end
            end
            chk($sformatf("s1_lat%0d", b), 128'(lat1), 128'(32));
            chk($sformatf("s32_lat%0d", b), 128'(lat32), 128'(1));
            chk($sformatf("s1_y%0d", b), y1r, exp);
            chk($sformatf("s32_y%0d", b), y32r, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serpent_sbox_iter.md
Name: serpent_sbox_iter

Overview:
- Iterative, parametrised Serpent substitution unit operating on one 128-bit block held as four 32-bit bit-plane words (x0..x3).
- Processes SLICES 4-bit bit-slices per clock.
- S-box index (0..7) and direction (forward/inverse) are selected at run time, per block.
- Sits between the key-mixing stage and the linear transform in the round datapath; trades area against latency under the SLICES parameter.
- Uses a valid/ready handshake on both sides.

Parameters:
- SLICES, 4, bit-slices substituted per cycle; legal values 1, 2, 4, 8, 16, 32; any other value is an elaboration error.
- N (localparam), 32/SLICES, number of compute cycles per block.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  unit can accept a block this cycle.
- sel  in  3  S-box index 0..7; sampled on acceptance.
- dec  in  1  1 = inverse S-box, 0 = forward; sampled on acceptance.
- x0, x1, x2, x3  in  32 each  input bit-planes; slice i is {x3[i], x2[i], x1[i], x0[i]}.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y0, y1, y2, y3  out  32 each  output bit-planes; slice i output is {y3[i], y2[i], y1[i], y0[i]}.
- busy  out  1  high while in BUSY state.

Behaviour:
- Reset
  - rst is sampled on the clock edge only; it has priority over everything else.
  - State goes to IDLE and the slice counter clears to 0.
  - y0..y3 clear to 0, out_valid=0, busy=0, in_ready=1 in the cycle after reset.
  - rst asserted mid-block aborts the block; no partial result is ever presented.
- Acceptance
  - A block is accepted on an edge where in_valid && in_ready.
  - On acceptance: x0..x3, sel and dec are captured into internal registers, the counter loads 0, and the state goes to BUSY.
  - Inputs may change freely after acceptance.
- States
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - BUSY: in_ready=0, busy=1.
    - Each edge substitutes slices [cnt*SLICES +: SLICES] of the captured block, writes them into the y registers, and increments cnt.
    - On the edge where cnt==N-1, the state goes to DONE.
  - DONE: out_valid=1, y0..y3 hold the full result and stay stable while out_ready=0.
    - in_ready = out_ready (combinational).
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=1 with in_valid=1: the result is consumed and a new block is accepted on the same edge; go to BUSY.
- Latency and throughput
  - out_valid rises exactly N cycles after the acceptance edge; SLICES=32 gives 1 cycle, SLICES=1 gives 32.
  - Back-to-back throughput is one block per N+1 cycles.
- Output register contents
  - y bits of slices not yet processed in BUSY are don't-care; the bench checks y only when out_valid=1.
  - y0..y3 are registered outputs; there is no combinational path from x to y.
- Substitution function
  - Forward: standard Serpent S0..S7, selected by the captured sel.
  - Inverse: InvS0..InvS7, selected by the captured sel.
  - Each slice lookup is purely combinational from the captured registers.
- Counter: width $clog2(N) with a minimum of 1; for SLICES=32 the single BUSY cycle completes the block directly.
- Handshake corner cases
  - out_ready high while not in DONE is ignored.
  - in_valid high while in BUSY is held off (in_ready=0) with no side effect.

Optional Feature:
- SERPENT_SBOX_INVERSE_EN
  - Defined: the inverse S-box tables are compiled in and dec is honoured as described above.
  - Undefined: the inverse tables are not built, dec is ignored and treated as 0, and every block uses forward S-boxes; port list is unchanged.

Test Plan:
- SLICES=4, sel=0, dec=0, x0..x3=0 -> out_valid exactly 8 cycles after acceptance; y0=y1=FFFFFFFF, y2=y3=00000000.
- sel=7, dec=0, x0..x3=FFFFFFFF -> y0=00000000, y1=y2=FFFFFFFF, y3=00000000.
- With SERPENT_SBOX_INVERSE_EN defined: sel=0, dec=1, x0=x1=FFFFFFFF, x2=x3=0 -> all y=0. Repeat for random x and all sel, checking that inverse(forward(x))==x.
- Hold out_ready=0 for 5 cycles in DONE -> y stable and in_ready=0; then raise out_ready together with in_valid -> next block accepted on the same edge, next out_valid exactly N cycles later.
- Assert rst at cnt=3 mid-block -> next cycle out_valid=0, y=0, in_ready=1, and no result is emitted for the aborted block.
- Sweep SLICES=1 and SLICES=32 with 100 random blocks each against a reference model -> latency is 32 and 1 cycles respectively; all results match.
